mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter placing fetch and data requests onto one single-port memory.
// One transaction at a time: grant in IDLE, LAT cycles in BUSY, one RESP cycle.
module mem_port_arbiter #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_f,
    output logic        stall_m,
    output logic [15:0] conflict_cnt
);

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_dm_q, owner_dm_d;
    logic        prev_dm_q, prev_dm_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic [15:0] conflict_q, conflict_d;
    logic        contend;
    logic        pick_dm;

    always_comb begin
        state_d    = state_q;
        owner_dm_d = owner_dm_q;
        prev_dm_d  = prev_dm_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        conflict_d = conflict_q;
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        contend    = if_req && dm_req;
        // dm normally wins; on contention fetch gets its turn right after a dm grant
        pick_dm    = dm_req && !(contend && prev_dm_q);

        case (state_q)
            IDLE: begin
                if (!rst && (if_req || dm_req)) begin
                    if_gnt     = !pick_dm;
                    dm_gnt     = pick_dm;
                    owner_dm_d = pick_dm;
                    prev_dm_d  = pick_dm;
                    addr_d     = pick_dm ? dm_addr : if_addr;
                    wdata_d    = pick_dm ? dm_wdata : 32'd0;
                    we_d       = pick_dm && dm_we;
                    cnt_d      = CNT_INIT;
                    state_d    = BUSY;
                end
                if (contend && (conflict_q != 16'hFFFF)) begin
                    conflict_d = conflict_q + 16'd1;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    if (owner_dm_q) begin
                        dm_rdata_d = we_q ? 32'd0 : mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_dm_q <= 1'b0;
            prev_dm_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            cnt_q      <= 4'd0;
            if_rdata_q <= 32'd0;
            dm_rdata_q <= 32'd0;
            conflict_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            owner_dm_q <= owner_dm_d;
            prev_dm_q  <= prev_dm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            conflict_q <= conflict_d;
        end
    end

    // The counter still holds its load value only in the first BUSY cycle
    assign mem_we       = (state_q == BUSY) && (cnt_q == CNT_INIT) && we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign if_rvalid    = (state_q == RESP) && !owner_dm_q;
    assign dm_rvalid    = (state_q == RESP) && owner_dm_q;
    assign if_rdata     = if_rdata_q;
    assign dm_rdata     = dm_rdata_q;
    assign stall_f      = if_req && !if_rvalid;
    assign stall_m      = dm_req && !dm_rvalid;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (LAT=2): directed scenarios plus a randomized run
// against a transaction-timing model of the arbiter.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = 32'd0;
    logic [31:0] dm_wdata = 32'd0;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_f, stall_m;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h40) return 32'h1234ABCD;
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    assign mem_rdata = mem_fn(mem_addr);

    mem_port_arbiter #(.LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m),
        .conflict_cnt(conflict_cnt)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = 32'd0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0;
    endtask

    // Leaves the bench at posedge+1 of the first cycle after reset release.
    task automatic apply_reset(input logic ifr, input logic dmr);
        clear_inputs();
        rst = 1'b1;
        if_req = ifr; dm_req = dmr; if_addr = 32'h80; dm_addr = 32'h84;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_we} !== 5'b0) begin
                errors++; $display("FAIL rst_ctrl got %b exp 00000", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_we});
            end
            checks++;
            if ({mem_addr, mem_wdata} !== 64'd0) begin
                errors++; $display("FAIL rst_mem got %h exp 0", {mem_addr, mem_wdata});
            end
            checks++;
            if ({if_rdata, dm_rdata} !== 64'd0) begin
                errors++; $display("FAIL rst_rdata got %h exp 0", {if_rdata, dm_rdata});
            end
            checks++;
            if (conflict_cnt !== 16'd0) begin
                errors++; $display("FAIL rst_conflict got %h exp 0", conflict_cnt);
            end
        end
    endtask

    // Both ports request continuously; after reset the record says "if", so
    // the rules give dm first and then alternate every LAT+2 cycles.
    task automatic test_alternation();
        logic last_dm = 1'b0;
        logic own_dm = 1'b0;
        logic [1:0] e_g, e_v;
        int n = 0;
        apply_reset(1'b1, 1'b1);
        for (int c = 0; c < 16; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            e_g = 2'b00;
            if (c % (LAT + 2) == 0) e_g = last_dm ? 2'b10 : 2'b01;
            e_v = 2'b00;
            if (c % (LAT + 2) == LAT + 1) e_v = own_dm ? 2'b01 : 2'b10;
            checks++;
            if ({if_gnt, dm_gnt} !== e_g) begin
                errors++; $display("FAIL alt_gnt c%0d got %b exp %b", c, {if_gnt, dm_gnt}, e_g);
            end
            checks++;
            if ({if_rvalid, dm_rvalid} !== e_v) begin
                errors++; $display("FAIL alt_rvalid c%0d got %b exp %b", c, {if_rvalid, dm_rvalid}, e_v);
            end
            checks++;
            if (conflict_cnt !== 16'(n)) begin
                errors++; $display("FAIL alt_conflict c%0d got %0d exp %0d", c, conflict_cnt, n);
            end
            if (e_g != 2'b00) begin
                own_dm = e_g[0]; last_dm = e_g[0]; n++;
            end
        end
    endtask

    task automatic test_fetch_read();
        apply_reset(1'b0, 1'b0);
        if_req = 1'b1; if_addr = 32'h40;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) next_cycle();
            if (c == 4) if_req = 1'b0;
            @(negedge clk);
            checks++;
            if ({if_gnt, dm_gnt} !== {c == 0, 1'b0}) begin
                errors++; $display("FAIL rd_gnt c%0d got %b exp %b", c, {if_gnt, dm_gnt}, {c == 0, 1'b0});
            end
            checks++;
            if (if_rvalid !== (c == 3)) begin
                errors++; $display("FAIL rd_rvalid c%0d got %b exp %b", c, if_rvalid, c == 3);
            end
            checks++;
            if (stall_f !== (c < 3)) begin
                errors++; $display("FAIL rd_stall_f c%0d got %b exp %b", c, stall_f, c < 3);
            end
            if (c >= 1) begin
                checks++;
                if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin
                    errors++; $display("FAIL rd_mem c%0d got %h/%b exp 00000040/0", c, mem_addr, mem_we);
                end
            end
            if (c >= 3) begin
                checks++;
                if (if_rdata !== 32'h1234ABCD) begin
                    errors++; $display("FAIL rd_data c%0d got %h exp 1234abcd", c, if_rdata);
                end
            end
        end
    endtask

    task automatic test_resp_hold();
        logic e_g, e_v;
        next_cycle();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) next_cycle();
            if (c == 8) dm_req = 1'b0;
            @(negedge clk);
            e_g = (c == 0) || (c == 4);
            e_v = (c == 3) || (c == 7);
            checks++;
            if ({if_gnt, dm_gnt} !== {1'b0, e_g}) begin
                errors++; $display("FAIL hold_gnt c%0d got %b exp %b", c, {if_gnt, dm_gnt}, {1'b0, e_g});
            end
            checks++;
            if (dm_rvalid !== e_v) begin
                errors++; $display("FAIL hold_rvalid c%0d got %b exp %b", c, dm_rvalid, e_v);
            end
            checks++;
            if (stall_m !== (dm_req && !e_v)) begin
                errors++; $display("FAIL hold_stall_m c%0d got %b exp %b", c, stall_m, dm_req && !e_v);
            end
            if (c == 3) begin
                checks++;
                if (dm_rdata !== mem_fn(32'h300)) begin
                    errors++; $display("FAIL hold_rdata got %h exp %h", dm_rdata, mem_fn(32'h300));
                end
            end
        end
    endtask

    task automatic test_write();
        next_cycle();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) next_cycle();
            if (c == 4) begin dm_req = 1'b0; dm_we = 1'b0; end
            @(negedge clk);
            checks++;
            if (dm_gnt !== (c == 0)) begin
                errors++; $display("FAIL wr_gnt c%0d got %b exp %b", c, dm_gnt, c == 0);
            end
            checks++;
            if (mem_we !== (c == 1)) begin
                errors++; $display("FAIL wr_mem_we c%0d got %b exp %b", c, mem_we, c == 1);
            end
            checks++;
            if (dm_rvalid !== (c == 3)) begin
                errors++; $display("FAIL wr_rvalid c%0d got %b exp %b", c, dm_rvalid, c == 3);
            end
            if (c >= 1) begin
                checks++;
                if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
                    errors++; $display("FAIL wr_mem c%0d got %h/%h exp 00000100/deadbeef", c, mem_addr, mem_wdata);
                end
            end
            if (c == 3) begin
                checks++;
                if (dm_rdata !== 32'd0) begin
                    errors++; $display("FAIL wr_rdata got %h exp 0", dm_rdata);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        next_cycle();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hCAFEF00D;
        @(negedge clk);
        checks++;
        if (dm_gnt !== 1'b1) begin
            errors++; $display("FAIL abort_gnt0 got %b exp 1", dm_gnt);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin
            errors++; $display("FAIL abort_we1 got %b exp 1", mem_we);
        end
        next_cycle();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_we, dm_gnt, dm_rvalid, if_rvalid} !== 4'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            errors++; $display("FAIL abort_now got %b %h %h exp 0000 0 0", {mem_we, dm_gnt, dm_rvalid, if_rvalid}, mem_addr, mem_wdata);
        end
        @(negedge clk);
        next_cycle();
        checks++;
        if ({dm_rvalid, if_rvalid} !== 2'b00) begin
            errors++; $display("FAIL abort_rvalid got %b exp 00", {dm_rvalid, if_rvalid});
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) next_cycle();
            if (k == 4) begin dm_req = 1'b0; dm_we = 1'b0; end
            @(negedge clk);
            checks++;
            if ({dm_gnt, mem_we, dm_rvalid} !== {k == 0, k == 1, k == 3}) begin
                errors++; $display("FAIL abort_retry k%0d got %b exp %b", k, {dm_gnt, mem_we, dm_rvalid}, {k == 0, k == 1, k == 3});
            end
        end
    endtask

    task automatic test_random();
        int free_at = 0, done_at = -1, grant_at = -10, e_conf = 0;
        logic last_dm = 1'b0, own_dm = 1'b0, g_we = 1'b0, wd, idle;
        logic [31:0] g_addr = 32'd0, g_wdata = 32'd0, e_addr, e_wdata;
        logic [31:0] e_if_rd = 32'd0, e_dm_rd = 32'd0;
        logic e_ig, e_dg, e_iv, e_dv, e_we;
        bit if_act = 0, if_got = 0, if_drop = 0, dm_act = 0, dm_got = 0, dm_drop = 0;
        apply_reset(1'b0, 1'b0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) next_cycle();
            if (if_drop) begin
                if_req = 1'b0; if_act = 0; if_drop = 0;
            end else if (!if_act) begin
                if ($urandom_range(1, 0) == 1) begin
                    if_act = 1; if_req = 1'b1; if_addr = 32'($urandom_range(1023, 0)) << 2;
                end
            end else if (!if_got && $urandom_range(7, 0) == 0) begin
                if_req = 1'b0; if_act = 0;
            end
            if (dm_drop) begin
                dm_req = 1'b0; dm_act = 0; dm_drop = 0;
            end else if (!dm_act) begin
                if ($urandom_range(1, 0) == 1) begin
                    dm_act = 1; dm_req = 1'b1; dm_we = 1'($urandom_range(1, 0));
                    dm_addr = 32'($urandom_range(1023, 0)) << 2; dm_wdata = $urandom;
                end
            end else if (!dm_got && $urandom_range(7, 0) == 0) begin
                dm_req = 1'b0; dm_act = 0;
            end
            // Timing model: grant at g, completion at g+LAT+1, next grant from g+LAT+2
            idle    = (cyc >= free_at);
            e_iv    = (cyc == done_at) && !own_dm;
            e_dv    = (cyc == done_at) && own_dm;
            e_we    = (cyc == grant_at + 1) && g_we;
            e_addr  = g_addr;
            e_wdata = g_wdata;
            if (e_iv) e_if_rd = mem_fn(g_addr);
            if (e_dv) e_dm_rd = g_we ? 32'd0 : mem_fn(g_addr);
            e_ig = 1'b0; e_dg = 1'b0;
            if (idle && (if_req || dm_req)) begin
                wd = dm_req && !(if_req && last_dm);
                e_dg = wd; e_ig = !wd;
                own_dm = wd; last_dm = wd;
                g_addr = wd ? dm_addr : if_addr;
                g_wdata = wd ? dm_wdata : 32'd0;
                g_we = wd && dm_we;
                grant_at = cyc; done_at = cyc + LAT + 1; free_at = cyc + LAT + 2;
            end
            @(negedge clk);
            checks++;
            if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_we} !== {e_ig, e_dg, e_iv, e_dv, e_we}) begin
                errors++; $display("FAIL rnd_ctrl cyc%0d got %b exp %b", cyc, {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_we}, {e_ig, e_dg, e_iv, e_dv, e_we});
            end
            checks++;
            if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin
                errors++; $display("FAIL rnd_mem cyc%0d got %h/%h exp %h/%h", cyc, mem_addr, mem_wdata, e_addr, e_wdata);
            end
            checks++;
            if (if_rdata !== e_if_rd || dm_rdata !== e_dm_rd) begin
                errors++; $display("FAIL rnd_rdata cyc%0d got %h/%h exp %h/%h", cyc, if_rdata, dm_rdata, e_if_rd, e_dm_rd);
            end
            checks++;
            if ({stall_f, stall_m} !== {if_req && !e_iv, dm_req && !e_dv}) begin
                errors++; $display("FAIL rnd_stall cyc%0d got %b exp %b", cyc, {stall_f, stall_m}, {if_req && !e_iv, dm_req && !e_dv});
            end
            checks++;
            if (conflict_cnt !== 16'(e_conf)) begin
                errors++; $display("FAIL rnd_conflict cyc%0d got %0d exp %0d", cyc, conflict_cnt, e_conf);
            end
            if (idle && if_req && dm_req && e_conf < 65535) e_conf++;
            if (e_ig) if_got = 1;
            if (e_dg) dm_got = 1;
            if (e_iv) begin if_got = 0; if_drop = 1; end
            if (e_dv) begin dm_got = 0; dm_drop = 1; end
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        int n, e;
        apply_reset(1'b1, 1'b1);
        for (int c = 0; c <= 65540 * (LAT + 2); c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            if (c % (LAT + 2) == 0) begin
                n = c / (LAT + 2);
                checks++;
                if ((if_gnt ^ dm_gnt) !== 1'b1) begin
                    errors++; $display("FAIL sat_gnt n%0d got %b exp one-hot", n, {if_gnt, dm_gnt});
                end
                if (n <= 1 || n >= 65534) begin
                    e = (n > 65535) ? 65535 : n;
                    checks++;
                    if (conflict_cnt !== 16'(e)) begin
                        errors++; $display("FAIL sat_conflict n%0d got %h exp %h", n, conflict_cnt, 16'(e));
                    end
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alternation();
        test_fetch_read();
        test_resp_hold();
        test_write();
        test_reset_abort();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
